stream_rr_arbiter: RTL and testbench

Packet-locked round-robin arbiter for the crossbar's master-side path, sitting directly upstream of the parallel coder (par_coder). It watches per-source AXI-Stream valid/last and the shared downstream ready. It issues a registered one-hot grant vector, which par_coder turns into the mux select ID. A grant is held for a whole packet, then released on the tlast handshake, after which priority rotates.

---
 rtl/stream_rr_arbiter.sv | 129 ++++++++++++
 tb/tb_stream_rr_arbiter.sv | 137 +++++++++++++
 2 files changed

// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter
// Packet-locked round-robin arbiter for one crossbar master port. A source
// keeps its one-hot grant for a whole packet and gives it up on the tlast
// handshake. Priority then rotates to the next source, and a new winner is
// loaded on the same edge so consecutive packets have no bubble between them.
module stream_rr_arbiter #(
  parameter int S_DATA_COUNT = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [S_DATA_COUNT-1:0] s_valid_i,
  input  logic [S_DATA_COUNT-1:0] s_last_i,
  input  logic                    m_ready_i,
  output logic [S_DATA_COUNT-1:0] s_ready_o,
  output logic                    m_valid_o,
  output logic [S_DATA_COUNT-1:0] grant_vec_o,
  output logic                    busy_o
);

  localparam int T_ID_M_WIDTH = $clog2(S_DATA_COUNT);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t                  r_state;
  logic [S_DATA_COUNT-1:0] r_grant;
  logic [T_ID_M_WIDTH-1:0] r_ptr;

  state_t                  w_nextState;
  logic [S_DATA_COUNT-1:0] w_nextGrant;
  logic [T_ID_M_WIDTH-1:0] w_nextPtr;
  logic [T_ID_M_WIDTH-1:0] w_gIdx;
  logic [T_ID_M_WIDTH-1:0] w_ptrAfter;
  logic [T_ID_M_WIDTH-1:0] w_searchStart;
  logic                    w_release;
  logic                    w_found;
  logic [S_DATA_COUNT-1:0] w_winVec;
  int                      w_idx;

  // Encode the one-hot grant back into an index and work out the pointer
  // that follows it. An explicit wrap keeps non-power-of-two counts correct.
  always_comb begin
    w_gIdx = '0;
    for (int i = 0; i < S_DATA_COUNT; i++) begin
      if (r_grant[i]) begin
        w_gIdx = T_ID_M_WIDTH'(i);
      end
    end
    w_ptrAfter = (w_gIdx == T_ID_M_WIDTH'(S_DATA_COUNT - 1)) ? '0
                                                              : w_gIdx + T_ID_M_WIDTH'(1);
  end

  // The last-beat handshake of the granted source releases the lock. A valid
  // drop on the granted source is an upstream fault and does not release it.
  always_comb begin
    w_release = (r_state == LOCKED) && m_ready_i &&
                (|(r_grant & s_valid_i & s_last_i));
  end

  // Pick the first valid source searching upward from the start point, with
  // wrap. In the release cycle the search starts just past the releasing
  // source, so that source can only win again if nobody else is waiting.
  always_comb begin
    w_searchStart = (r_state == LOCKED) ? w_ptrAfter : r_ptr;
    w_found       = 1'b0;
    w_winVec      = '0;
    w_idx         = 0;
    for (int i = 0; i < S_DATA_COUNT; i++) begin
      w_idx = (int'(w_searchStart) + i) % S_DATA_COUNT;
      if (!w_found && s_valid_i[w_idx]) begin
        w_found         = 1'b1;
        w_winVec        = '0;
        w_winVec[w_idx] = 1'b1;
      end
    end
  end

  // Next-state logic. IDLE grabs any requester. LOCKED changes only on
  // release, where it re-arbitrates immediately or drops back to IDLE.
  always_comb begin
    w_nextState = r_state;
    w_nextGrant = r_grant;
    w_nextPtr   = r_ptr;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_nextState = LOCKED;
          w_nextGrant = w_winVec;
        end
      end
      LOCKED: begin
        if (w_release) begin
          w_nextPtr = w_ptrAfter;
          if (w_found) begin
            w_nextGrant = w_winVec;
          end else begin
            w_nextState = IDLE;
            w_nextGrant = '0;
          end
        end
      end
      default: begin
        w_nextState = IDLE;
        w_nextGrant = '0;
      end
    endcase
  end

  // State, grant and pointer registers. Reset abandons any packet in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_nextState;
      r_grant <= w_nextGrant;
      r_ptr   <= w_nextPtr;
    end
  end

  assign grant_vec_o = r_grant;
  assign busy_o      = (r_state == LOCKED);
  assign s_ready_o   = r_grant & {S_DATA_COUNT{m_ready_i}};
  assign m_valid_o   = |(r_grant & s_valid_i);

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// tb_stream_rr_arbiter
// Directed bench for a 4-source arbiter. Each cycle drives inputs on the
// falling edge and compares outputs against hand-computed grant expectations.
module tb_stream_rr_arbiter;

  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [S-1:0] s_valid_i;
  logic [S-1:0] s_last_i;
  logic         m_ready_i;
  logic [S-1:0] s_ready_o;
  logic         m_valid_o;
  logic [S-1:0] grant_vec_o;
  logic         busy_o;

  int checkCount = 0;
  int failCount  = 0;

  stream_rr_arbiter #(.S_DATA_COUNT(S)) dut (
    .clk         (clk),
    .rst         (rst),
    .s_valid_i   (s_valid_i),
    .s_last_i    (s_last_i),
    .m_ready_i   (m_ready_i),
    .s_ready_o   (s_ready_o),
    .m_valid_o   (m_valid_o),
    .grant_vec_o (grant_vec_o),
    .busy_o      (busy_o)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs on the falling edge so they settle well
  // before the next rising edge.
  task automatic applyStimulus(input logic [S-1:0] v, input logic [S-1:0] l,
                               input logic r);
    @(negedge clk);
    s_valid_i = v;
    s_last_i  = l;
    m_ready_i = r;
    #1;
  endtask

  // Check the current cycle. The ready and valid expectations follow from
  // the expected grant and the driven inputs.
  task automatic expectCycle(input string tag, input logic [S-1:0] expGrant);
    checkOutput({tag, ".grant"},  32'(grant_vec_o), 32'(expGrant));
    checkOutput({tag, ".busy"},   32'(busy_o),      32'(|expGrant));
    checkOutput({tag, ".sready"}, 32'(s_ready_o),   32'(expGrant & {S{m_ready_i}}));
    checkOutput({tag, ".mvalid"}, 32'(m_valid_o),   32'(|(expGrant & s_valid_i)));
  endtask

  initial begin
    rst       = 1'b1;
    s_valid_i = '0;
    s_last_i  = '0;
    m_ready_i = 1'b1;
    repeat (2) @(posedge clk);

    // Idle after reset.
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b0000, 4'b0000, 1'b1);
      expectCycle("idle", 4'b0000);
    end

    // Single 3-beat packet from source 2. Grant appears one cycle after
    // valid. Source 2 stays valid on its last beat and is the only
    // requester, so it is re-granted for a second packet.
    applyStimulus(4'b0100, 4'b0000, 1'b1); expectCycle("pkt.req",   4'b0000);
    applyStimulus(4'b0100, 4'b0000, 1'b1); expectCycle("pkt.beat1", 4'b0100);
    applyStimulus(4'b0100, 4'b0000, 1'b1); expectCycle("pkt.beat2", 4'b0100);
    applyStimulus(4'b0100, 4'b0100, 1'b1); expectCycle("pkt.beat3", 4'b0100);
    // The second packet from source 2 ends with all sources valid. The
    // pointer after source 2 is 3, so source 3 wins.
    applyStimulus(4'b1111, 4'b0000, 1'b1); expectCycle("pkt2.beat1", 4'b0100);
    applyStimulus(4'b1111, 4'b0100, 1'b1); expectCycle("pkt2.last",  4'b0100);

    // All sources valid with 1-beat packets rotate with no gap.
    applyStimulus(4'b1111, 4'b1111, 1'b1); expectCycle("rr.g3", 4'b1000);
    applyStimulus(4'b1111, 4'b1111, 1'b1); expectCycle("rr.g0", 4'b0001);
    applyStimulus(4'b1111, 4'b1111, 1'b1); expectCycle("rr.g1", 4'b0010);
    applyStimulus(4'b1111, 4'b1111, 1'b1); expectCycle("rr.g2", 4'b0100);
    applyStimulus(4'b1111, 4'b1111, 1'b1); expectCycle("rr.g3b", 4'b1000);
    applyStimulus(4'b1111, 4'b1111, 1'b1); expectCycle("rr.g0b", 4'b0001);

    // Source 1 locked under backpressure while source 3 waits.
    applyStimulus(4'b1010, 4'b0000, 1'b1); expectCycle("bp.beat1",  4'b0010);
    applyStimulus(4'b1010, 4'b0000, 1'b0); expectCycle("bp.stall1", 4'b0010);
    applyStimulus(4'b1010, 4'b0010, 1'b0); expectCycle("bp.stall2", 4'b0010);
    applyStimulus(4'b1010, 4'b0010, 1'b1); expectCycle("bp.last",   4'b0010);

    // Source 3 releases with only itself valid. The pointer wraps to 0 and
    // source 3 is re-granted. Next time source 0 is also valid and wins.
    applyStimulus(4'b1000, 4'b1000, 1'b1); expectCycle("wrap.g3",   4'b1000);
    applyStimulus(4'b1001, 4'b1000, 1'b1); expectCycle("wrap.self", 4'b1000);
    applyStimulus(4'b0000, 4'b0000, 1'b1); expectCycle("wrap.g0",   4'b0001);
    // Valid drop on the granted source and requests from others keep the lock.
    applyStimulus(4'b0110, 4'b0000, 1'b1); expectCycle("hold.g0",   4'b0001);

    // Release source 0 into source 2, then reset on its second beat.
    applyStimulus(4'b0101, 4'b0001, 1'b1); expectCycle("rst.pre",   4'b0001);
    applyStimulus(4'b0100, 4'b0000, 1'b1); expectCycle("rst.beat1", 4'b0100);
    @(negedge clk);
    rst = 1'b1;
    s_valid_i = 4'b0100;
    s_last_i  = 4'b0000;
    m_ready_i = 1'b1;
    #1;
    expectCycle("rst.beat2", 4'b0100);
    @(negedge clk);
    rst = 1'b0;
    s_valid_i = 4'b1100;
    s_last_i  = 4'b0000;
    m_ready_i = 1'b1;
    #1;
    expectCycle("rst.after", 4'b0000);
    applyStimulus(4'b1100, 4'b0000, 1'b1); expectCycle("rst.regrant", 4'b0100);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
